// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
// Segment patterns are ordered {a,b,c,d,e,f,g,dp}, 1 = lit.
package seg7_pkg;

  localparam int unsigned SEG_W = 8;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned NIB_W = 4;

  localparam logic [SEG_W-1:0] SEG_0    = 8'b11111100;
  localparam logic [SEG_W-1:0] SEG_1    = 8'b01100000;
  localparam logic [SEG_W-1:0] SEG_2    = 8'b11011010;
  localparam logic [SEG_W-1:0] SEG_3    = 8'b11110010;
  localparam logic [SEG_W-1:0] SEG_4    = 8'b01100110;
  localparam logic [SEG_W-1:0] SEG_5    = 8'b10110110;
  localparam logic [SEG_W-1:0] SEG_6    = 8'b10111110;
  localparam logic [SEG_W-1:0] SEG_7    = 8'b11100000;
  localparam logic [SEG_W-1:0] SEG_8    = 8'b11111110;
  localparam logic [SEG_W-1:0] SEG_9    = 8'b11110110;
  localparam logic [SEG_W-1:0] SEG_DASH = 8'b00000010;
  localparam logic [SEG_W-1:0] SEG_OFF  = 8'b00000000;

  localparam logic [DIG_W-1:0] DIG_OFF  = 4'b1111;

  typedef enum logic {S_BLANK, S_ON} state_e;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// BCD frame load bus from the datapath into the scan controller.
interface seg7_scan_ctrl_if
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIG = 4
);
  logic                     i_load;
  logic [NIB_W*NUM_DIG-1:0] i_bcd;
  logic [NUM_DIG-1:0]       i_dp;

  modport master (output i_load, output i_bcd, output i_dp);
  modport slave  (input  i_load, input  i_bcd, input  i_dp);
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD nibble + decimal point to segment pattern; 10..15 show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  input  logic             dp_i,
  output logic [SEG_W-1:0] seg_c_o
);

  logic [SEG_W-1:0] pat_c;

  always_comb begin
    pat_c = SEG_DASH;
    case (nibble_i)
      4'd0:    pat_c = SEG_0;
      4'd1:    pat_c = SEG_1;
      4'd2:    pat_c = SEG_2;
      4'd3:    pat_c = SEG_3;
      4'd4:    pat_c = SEG_4;
      4'd5:    pat_c = SEG_5;
      4'd6:    pat_c = SEG_6;
      4'd7:    pat_c = SEG_7;
      4'd8:    pat_c = SEG_8;
      4'd9:    pat_c = SEG_9;
      default: pat_c = SEG_DASH;
    endcase
    seg_c_o = pat_c | {{(SEG_W-1){1'b0}}, dp_i};
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with double-buffered BCD frame.
// Optional leading-zero blanking is enabled by defining LZB_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIG    = 4,
  parameter int unsigned ON_WAIT    = 27_000,
  parameter int unsigned BLANK_WAIT = 270
) (
  input  logic              i_clk,
  input  logic              i_rst,
  seg7_scan_ctrl_if.slave   bus,
  output logic [SEG_W-1:0]  o_seg,
  output logic [DIG_W-1:0]  o_dig,
  output logic              o_frame
);

  localparam int unsigned WAIT_MAX = (ON_WAIT > BLANK_WAIT) ? ON_WAIT : BLANK_WAIT;
  localparam int unsigned TICK_W   = $clog2(WAIT_MAX);
  localparam int unsigned IDX_W    = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

  state_e                         state_q, state_d;
  logic [TICK_W-1:0]              tick_q, tick_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [NUM_DIG-1:0][NIB_W-1:0]  display_q, display_d;
  logic [NUM_DIG-1:0][NIB_W-1:0]  shadow_q, shadow_d;
  logic [NUM_DIG-1:0]             dp_q, dp_d;
  logic [NUM_DIG-1:0]             sdp_q, sdp_d;
  logic                           pending_q, pending_d;
  logic [SEG_W-1:0]               seg_q, seg_d;
  logic [DIG_W-1:0]               dig_q, dig_d;
  logic                           frame_q, frame_d;
  logic                           boundary_c;
  logic [SEG_W-1:0]               digit_seg_c;
  logic [NUM_DIG-1:0]             blank_c;

  seg7_decode u_decode (
    .nibble_i (display_q[idx_q]),
    .dp_i     (dp_q[idx_q]),
    .seg_c_o  (digit_seg_c)
  );

`ifdef LZB_EN
  // A digit is blanked while it and every digit above it are zero; digit 0 and dp digits stay lit.
  always_comb begin : lzb
    logic seen_nz;
    seen_nz = 1'b0;
    blank_c = '0;
    for (int k = int'(NUM_DIG) - 1; k > 0; k--) begin
      seen_nz    = seen_nz | (display_q[k] != '0);
      blank_c[k] = ~seen_nz & ~dp_q[k];
    end
  end
`else
  assign blank_c = '0;
`endif

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q + TICK_W'(1);
    idx_d      = idx_q;
    boundary_c = 1'b0;
    display_d  = display_q;
    dp_d       = dp_q;
    shadow_d   = shadow_q;
    sdp_d      = sdp_q;
    pending_d  = pending_q;
    seg_d      = SEG_OFF;
    dig_d      = DIG_OFF;

    case (state_q)
      S_BLANK: begin
        if (tick_q == TICK_W'(BLANK_WAIT - 1)) begin
          state_d = S_ON;
          tick_d  = '0;
        end
      end
      S_ON: begin
        dig_d[idx_q] = 1'b0;
        seg_d        = blank_c[idx_q] ? SEG_OFF : digit_seg_c;
        if (tick_q == TICK_W'(ON_WAIT - 1)) begin
          state_d = S_BLANK;
          tick_d  = '0;
          if (idx_q == IDX_W'(NUM_DIG - 1)) begin
            idx_d      = '0;
            boundary_c = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_BLANK;
    endcase

    // A load landing on the boundary bypasses the now-stale shadow.
    if (boundary_c) begin
      if (bus.i_load) begin
        display_d = bus.i_bcd;
        dp_d      = bus.i_dp;
      end else if (pending_q) begin
        display_d = shadow_q;
        dp_d      = sdp_q;
      end
      pending_d = 1'b0;
    end else if (bus.i_load) begin
      shadow_d  = bus.i_bcd;
      sdp_d     = bus.i_dp;
      pending_d = 1'b1;
    end

    // Raised for the cycle whose closing edge is the frame boundary.
    frame_d = (state_d == S_ON) && (tick_d == TICK_W'(ON_WAIT - 1)) &&
              (idx_d == IDX_W'(NUM_DIG - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_BLANK;
      tick_q    <= '0;
      idx_q     <= '0;
      display_q <= '0;
      shadow_q  <= '0;
      dp_q      <= '0;
      sdp_q     <= '0;
      pending_q <= 1'b0;
      seg_q     <= SEG_OFF;
      dig_q     <= DIG_OFF;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      idx_q     <= idx_d;
      display_q <= display_d;
      shadow_q  <= shadow_d;
      dp_q      <= dp_d;
      sdp_q     <= sdp_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      frame_q   <= frame_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_dig   = dig_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: per-cycle frame-arithmetic reference model, a vector table
// of frames with hand-derived digit patterns, and hand sequences for boundary/reset cases.
module tb_seg7_scan_ctrl;

  localparam int unsigned NUM_DIG    = 4;
  localparam int unsigned ON_WAIT    = 8;
  localparam int unsigned BLANK_WAIT = 2;
  localparam int          SLOT       = BLANK_WAIT + ON_WAIT;
  localparam int          FRAME      = NUM_DIG * SLOT;

`ifdef LZB_EN
  localparam logic [7:0] ZB = 8'h00;
`else
  localparam logic [7:0] ZB = 8'hFC;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] o_seg;
  logic [3:0] o_dig;
  logic       o_frame;

  seg7_scan_ctrl_if #(.NUM_DIG(NUM_DIG)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIG    (NUM_DIG),
    .ON_WAIT    (ON_WAIT),
    .BLANK_WAIT (BLANK_WAIT)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .bus     (bus),
    .o_seg   (o_seg),
    .o_dig   (o_dig),
    .o_frame (o_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  // Independent segment table for the model.
  function automatic logic [7:0] pat(input logic [3:0] v);
    case (v)
      4'd0: return 8'hFC;
      4'd1: return 8'h60;
      4'd2: return 8'hDA;
      4'd3: return 8'hF2;
      4'd4: return 8'h66;
      4'd5: return 8'hB6;
      4'd6: return 8'hBE;
      4'd7: return 8'hE0;
      4'd8: return 8'hFE;
      4'd9: return 8'hF6;
      default: return 8'h02;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(input logic [15:0] disp, input logic [3:0] dpv, input int k);
    logic [7:0] s;
    int         msd;
    s = pat(4'(disp >> (4 * k))) | {7'b0, dpv[k]};
    msd = 0;
    for (int j = 0; j < 4; j++) if (4'(disp >> (4 * j)) != 4'd0) msd = j;
`ifdef LZB_EN
    if (k > msd && !dpv[k]) s = 8'h00;
`endif
    return s;
  endfunction

  // Reference model: position in frame = edges since reset release mod FRAME.
  int         m_n, m_pos, m_slot, m_r;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_dp, m_sdp;
  bit          m_pend;
  logic [3:0]  exp_dig;
  logic [7:0]  exp_seg;
  logic        exp_frame;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_n = 0; m_disp = '0; m_shadow = '0; m_dp = '0; m_sdp = '0; m_pend = 1'b0;
      exp_dig = 4'hF; exp_seg = 8'h00; exp_frame = 1'b0;
    end else begin
      m_pos  = m_n % FRAME;
      m_slot = m_pos / SLOT;
      m_r    = m_pos % SLOT;
      if (m_r < BLANK_WAIT) begin
        exp_dig = 4'hF;
        exp_seg = 8'h00;
      end else begin
        exp_dig = ~(4'b0001 << m_slot);
        exp_seg = model_seg(m_disp, m_dp, m_slot);
      end
      exp_frame = ((m_n + 1) % FRAME) == (FRAME - 1);
      if (m_pos == FRAME - 1) begin
        if (bus.i_load) begin
          m_disp = bus.i_bcd; m_dp = bus.i_dp;
        end else if (m_pend) begin
          m_disp = m_shadow; m_dp = m_sdp;
        end
        m_pend = 1'b0;
      end else if (bus.i_load) begin
        m_shadow = bus.i_bcd; m_sdp = bus.i_dp; m_pend = 1'b1;
      end
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("dig",   32'(o_dig),   32'(exp_dig));
      check("seg",   32'(o_seg),   32'(exp_seg));
      check("frame", 32'(o_frame), 32'(exp_frame));
    end
  end

  logic [7:0] obs [4];

  task automatic wait_frame();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3 * FRAME && !got; i++) begin
      @(negedge clk);
      if (o_frame === 1'b1) got = 1'b1;
    end
    check("frame_seen", 32'(got), 32'd1);
  endtask

  // Record the pattern shown on each digit over one full frame.
  task automatic collect();
    for (int k = 0; k < 4; k++) obs[k] = 8'hEE;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) if (o_dig == ~(4'b0001 << k)) obs[k] = o_seg;
    end
  endtask

  task automatic do_load(input logic [15:0] bcd, input logic [3:0] dp);
    @(negedge clk);
    bus.i_load = 1'b1; bus.i_bcd = bcd; bus.i_dp = dp;
    @(negedge clk);
    bus.i_load = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0]     bcd;
    logic [3:0]      dp;
    logic [3:0][7:0] segs;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, {8'h60, 8'hDA, 8'hF2, 8'h66}};
    vecs[1] = '{16'h000A, 4'b0001, {ZB,    ZB,    ZB,    8'h03}};
    vecs[2] = '{16'h0050, 4'b0000, {ZB,    ZB,    8'hB6, 8'hFC}};
    vecs[3] = '{16'h5678, 4'b1000, {8'hB7, 8'hBE, 8'hE0, 8'hFE}};
    vecs[4] = '{16'h90F0, 4'b0000, {8'hF6, 8'hFC, 8'h02, 8'hFC}};
    vecs[5] = '{16'h0000, 4'b1000, {8'hFD, ZB,    ZB,    8'hFC}};

    rst = 1'b1;
    bus.i_load = 1'b0; bus.i_bcd = '0; bus.i_dp = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_dig",   32'(o_dig),   32'hF);
    check("rst_seg",   32'(o_seg),   32'h00);
    check("rst_frame", 32'(o_frame), 32'h0);
    rst = 1'b0;

    // Idle scan over a full frame and then some.
    repeat (FRAME + 5) @(negedge clk);

    // Vector table: load mid-frame, wait for commit, inspect next frame.
    for (int v = 0; v < 6; v++) begin
      repeat (7 + v) @(negedge clk);
      do_load(vecs[v].bcd, vecs[v].dp);
      wait_frame();
      collect();
      for (int k = 0; k < 4; k++)
        check($sformatf("vec%0d_dig%0d", v, k), 32'(obs[k]), 32'(vecs[v].segs[k]));
    end

    // Two loads in one frame: last one wins.
    wait_frame();
    repeat (5) @(negedge clk);
    do_load(16'h1111, 4'b0000);
    repeat (10) @(negedge clk);
    do_load(16'h2222, 4'b0000);
    wait_frame();
    collect();
    for (int k = 0; k < 4; k++) check($sformatf("last_wins_dig%0d", k), 32'(obs[k]), 32'hDA);

    // Load exactly on the boundary cycle.
    wait_frame();
    bus.i_load = 1'b1; bus.i_bcd = 16'h4321; bus.i_dp = 4'b0000;
    @(negedge clk);
    bus.i_load = 1'b0;
    collect();
    check("bnd_load_dig0", 32'(obs[0]), 32'h60);
    check("bnd_load_dig3", 32'(obs[3]), 32'h66);

    // Reset while a digit is lit and a load is pending.
    begin
      bit lit;
      lit = 1'b0;
      for (int i = 0; i < FRAME && !lit; i++) begin
        @(negedge clk);
        if (o_dig != 4'hF && o_frame == 1'b0) lit = 1'b1;
      end
      check("lit_seen", 32'(lit), 32'd1);
    end
    bus.i_load = 1'b1; bus.i_bcd = 16'h9999; bus.i_dp = 4'b1111;
    @(negedge clk);
    bus.i_load = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_dig", 32'(o_dig), 32'hF);
    check("mid_rst_seg", 32'(o_seg), 32'h00);
    rst = 1'b0;
    begin
      bit lit;
      lit = 1'b0;
      for (int i = 0; i < FRAME && !lit; i++) begin
        @(negedge clk);
        if (o_dig != 4'hF) lit = 1'b1;
      end
      check("restart_dig0", 32'(o_dig), 32'hE);
    end
    collect();
    check("post_rst_dig0", 32'(obs[0]), 32'hFC);
    for (int k = 1; k < 4; k++) check($sformatf("post_rst_dig%0d", k), 32'(obs[k]), 32'(ZB));

    // Randomized loads, gaps and occasional resets against the model.
    for (int it = 0; it < 300; it++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        do_load(16'($urandom), 4'($urandom));
      end
    end
    repeat (2 * FRAME) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
